// File: rtl/dpram32_port_master.sv
// dpram32_port_master: byte-addressed CPU bus to 32-bit byte-enabled BSRAM port initiator.
// Optional feature macro: DPRAM32_SPLIT_EN (enables split long accesses across a word boundary).
// A rejected request acks in its ERR cycle and returns straight to IDLE so the host may re-issue
// on the edge ending the cycle after ack.
module dpram32_port_master (
    input  logic        clk,
    input  logic        resetn,
    input  logic        req,
    input  logic        we,
    input  logic [11:0] addr,
    input  logic [1:0]  size,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ack,
    output logic        err,
    output logic [9:0]  ram_addr,
    output logic [31:0] ram_din,
    output logic        ram_we,
    output logic [3:0]  ram_be,
    input  logic [31:0] ram_dout
);
`ifdef DPRAM32_SPLIT_EN
    typedef enum logic [2:0] {S_IDLE, S_WR, S_WR2, S_RD, S_RD2, S_RDW, S_ERR, S_ACK} state_t;
    localparam logic SPLIT_EN = 1'b1;
    logic [9:0]  r_word;
    logic [15:0] r_whi;
`else
    typedef enum logic [2:0] {S_IDLE, S_WR, S_RD, S_RDW, S_ERR, S_ACK} state_t;
    localparam logic SPLIT_EN = 1'b0;
`endif
    state_t      r_state;
    state_t      w_next;
    logic [1:0]  r_size;
    logic [1:0]  r_lane;
    logic        w_bad;
    logic        w_half;
    logic        w_split;
    logic [3:0]  w_be;
    logic [31:0] w_din;
    logic [31:0] w_sh;
    logic [31:0] w_rd;

    // Decode the live request for alignment, lanes and write data placement.
    always_comb begin
        w_bad  = (size == 2'd3) || (size != 2'd0 && addr[0]) || (!SPLIT_EN && size == 2'd2 && addr[1]);
        w_half = (size == 2'd1) || addr[1];
        w_be   = (size == 2'd0) ? (4'b0001 << addr[1:0]) : !w_half ? 4'hF : addr[1] ? 4'hC : 4'h3;
        w_din  = (size == 2'd0) ? ({24'h0, wdata[7:0]} << {addr[1:0], 3'b000}) :
                 !w_half ? wdata : addr[1] ? {wdata[15:0], 16'h0} : {16'h0, wdata[15:0]};
        w_split = SPLIT_EN && r_size == 2'd2 && r_lane[1];
        w_sh    = ram_dout >> {r_lane, 3'b000};
        w_rd    = (r_size == 2'd0) ? {24'h0, w_sh[7:0]} : (r_size == 2'd1) ? {16'h0, w_sh[15:0]} : ram_dout;
    end

    // Next-state selection.
    always_comb begin
        w_next = S_IDLE;
        case (r_state)
            S_IDLE: w_next = !req ? S_IDLE : w_bad ? S_ERR : we ? S_WR : S_RD;
`ifdef DPRAM32_SPLIT_EN
            S_WR:   w_next = w_split ? S_WR2 : S_ACK;
            S_WR2:  w_next = S_ACK;
            S_RD:   w_next = w_split ? S_RD2 : S_RDW;
            S_RD2:  w_next = S_RDW;
`else
            S_WR:   w_next = S_ACK;
            S_RD:   w_next = S_RDW;
`endif
            S_RDW:  w_next = S_ACK;
            default: w_next = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) r_state <= S_IDLE;
        else         r_state <= w_next;
    end

    // Registered outputs are computed from the state being entered; request fields latch on accept.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ack      <= 1'b0;
            err      <= 1'b0;
            rdata    <= 32'h0;
            ram_we   <= 1'b0;
            ram_be   <= 4'h0;
            ram_addr <= 10'h0;
            ram_din  <= 32'h0;
            r_size   <= 2'd0;
            r_lane   <= 2'd0;
`ifdef DPRAM32_SPLIT_EN
            r_word   <= 10'h0;
            r_whi    <= 16'h0;
`endif
        end else begin
            ack    <= (w_next == S_ACK) || (w_next == S_ERR);
            err    <= (w_next == S_ERR);
            ram_we <= (w_next == S_WR);
            ram_be <= (w_next == S_WR) ? w_be : 4'h0;
            if (w_next == S_WR || w_next == S_RD) ram_addr <= addr[11:2];
            if (w_next == S_WR) ram_din <= w_din;
            if (r_state == S_IDLE && req) begin
                r_size <= size;
                r_lane <= addr[1:0];
`ifdef DPRAM32_SPLIT_EN
                r_word <= addr[11:2];
                r_whi  <= wdata[31:16];
`endif
            end
`ifdef DPRAM32_SPLIT_EN
            if (w_next == S_WR2) begin
                ram_we  <= 1'b1;
                ram_be  <= 4'h3;
                ram_din <= {16'h0, r_whi};
            end
            if (w_next == S_WR2 || w_next == S_RD2) ram_addr <= r_word + 10'd1;
            if (r_state == S_RD2) rdata <= {16'h0, ram_dout[31:16]};
`endif
            if (r_state == S_RDW) rdata <= w_split ? {ram_dout[15:0], rdata[15:0]} : w_rd;
        end
    end
endmodule

// File: tb/tb_dpram32_port_master.sv
// tb_dpram32_port_master: directed table-driven bench with a behavioural BSRAM model.
module tb_dpram32_port_master;
    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic [11:0] addr = 12'h0;
    logic [1:0]  size = 2'd0;
    logic [31:0] wdata = 32'h0;
    logic [31:0] rdata;
    logic        ack;
    logic        err;
    logic [9:0]  ram_addr;
    logic [31:0] ram_din;
    logic        ram_we;
    logic [3:0]  ram_be;
    logic [31:0] ram_dout = 32'h0;
    logic [31:0] mem [1024];
    int          n_chk = 0;
    int          n_fail = 0;

    typedef struct {
        logic        w;
        logic [11:0] a;
        logic [1:0]  s;
        logic [31:0] d;
        logic        e;
        int          lat;
        int          ns;
        logic [9:0]  a1;
        logic [3:0]  b1;
        logic [31:0] d1;
        logic [9:0]  a2;
        logic [3:0]  b2;
        logic [31:0] d2;
        logic [31:0] rd;
    } vec_t;

    vec_t tbl[$];

    dpram32_port_master dut (
        .clk(clk), .resetn(resetn), .req(req), .we(we), .addr(addr), .size(size), .wdata(wdata),
        .rdata(rdata), .ack(ack), .err(err), .ram_addr(ram_addr), .ram_din(ram_din),
        .ram_we(ram_we), .ram_be(ram_be), .ram_dout(ram_dout)
    );

    always #5 clk = ~clk;

    // RAM port model: byte-enabled write, registered read.
    always @(posedge clk) begin
        if (ram_we)
            for (int i = 0; i < 4; i++)
                if (ram_be[i]) mem[ram_addr][i*8 +: 8] <= ram_din[i*8 +: 8];
        ram_dout <= mem[ram_addr];
    end

    function automatic vec_t v(logic w, logic [11:0] a, logic [1:0] s, logic [31:0] d, logic e, int lat, int ns,
                               logic [9:0] a1, logic [3:0] b1, logic [31:0] d1,
                               logic [9:0] a2, logic [3:0] b2, logic [31:0] d2, logic [31:0] rd);
        vec_t t;
        t.w = w; t.a = a; t.s = s; t.d = d; t.e = e; t.lat = lat; t.ns = ns;
        t.a1 = a1; t.b1 = b1; t.d1 = d1; t.a2 = a2; t.b2 = b2; t.d2 = d2; t.rd = rd;
        return t;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Called at a negedge with the DUT idle; returns at the negedge of the cycle after ack.
    task automatic run(input vec_t t, input int idx);
        int ack_cyc = -1;
        int ns = 0;
        int be_rd = 0;
        logic e = 1'b0;
        logic [31:0] rd = 32'h0;
        logic [9:0] a1 = 10'h0, a2 = 10'h0;
        logic [3:0] b1 = 4'h0, b2 = 4'h0;
        logic [31:0] d1 = 32'h0, d2 = 32'h0;
        req = 1'b1; we = t.w; addr = t.a; size = t.s; wdata = t.d;
        @(posedge clk);
        #1;
        req = 1'b0; we = ~t.w; addr = ~t.a; size = ~t.s; wdata = ~t.d;
        for (int c = 1; c <= 8 && ack_cyc < 0; c++) begin
            @(negedge clk);
            if (ram_we) begin
                ns++;
                if (ns == 1) begin a1 = ram_addr; b1 = ram_be; d1 = ram_din; end
                else begin a2 = ram_addr; b2 = ram_be; d2 = ram_din; end
            end
            if (!t.w && ram_be != 4'h0) be_rd++;
            if (ack) begin ack_cyc = c; e = err; rd = rdata; end
        end
        chk($sformatf("v%0d_ack_cycle", idx), ack_cyc, t.lat);
        chk($sformatf("v%0d_err", idx), {31'h0, e}, {31'h0, t.e});
        chk($sformatf("v%0d_strobes", idx), ns, t.ns);
        if (t.ns > 0) begin
            chk($sformatf("v%0d_addr1", idx), {22'h0, a1}, {22'h0, t.a1});
            chk($sformatf("v%0d_be1", idx), {28'h0, b1}, {28'h0, t.b1});
            chk($sformatf("v%0d_din1", idx), d1, t.d1);
        end
        if (t.ns > 1) begin
            chk($sformatf("v%0d_addr2", idx), {22'h0, a2}, {22'h0, t.a2});
            chk($sformatf("v%0d_be2", idx), {28'h0, b2}, {28'h0, t.b2});
            chk($sformatf("v%0d_din2", idx), d2, t.d2);
        end
        if (!t.w && !t.e) begin
            chk($sformatf("v%0d_rdata", idx), rd, t.rd);
            chk($sformatf("v%0d_read_be", idx), be_rd, 0);
        end
        @(negedge clk);
        chk($sformatf("v%0d_ack_pulse", idx), {31'h0, ack}, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
        tbl.push_back(v(1, 12'h007, 2'd0, 32'h000000A5, 0, 2, 1, 10'h001, 4'b1000, 32'hA5000000, 0, 0, 0, 0));
        tbl.push_back(v(1, 12'h102, 2'd1, 32'h00001234, 0, 2, 1, 10'h040, 4'b1100, 32'h12340000, 0, 0, 0, 0));
        tbl.push_back(v(0, 12'h102, 2'd1, 32'h0, 0, 3, 0, 0, 0, 0, 0, 0, 0, 32'h00001234));
`ifdef DPRAM32_SPLIT_EN
        tbl.push_back(v(1, 12'hFFE, 2'd2, 32'hDEADBEEF, 0, 3, 2, 10'h3FF, 4'b1100, 32'hBEEF0000, 10'h000, 4'b0011, 32'h0000DEAD, 0));
        tbl.push_back(v(0, 12'hFFE, 2'd2, 32'h0, 0, 4, 0, 0, 0, 0, 0, 0, 0, 32'hDEADBEEF));
`else
        tbl.push_back(v(1, 12'hFFE, 2'd2, 32'hDEADBEEF, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, 12'hFFE, 2'd2, 32'h0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0));
`endif
        tbl.push_back(v(0, 12'h003, 2'd1, 32'h0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(v(1, 12'h000, 2'd3, 32'h12345678, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, 12'h001, 2'd2, 32'h0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(v(1, 12'h010, 2'd2, 32'h11223344, 0, 2, 1, 10'h004, 4'b1111, 32'h11223344, 0, 0, 0, 0));
        tbl.push_back(v(0, 12'h013, 2'd0, 32'h0, 0, 3, 0, 0, 0, 0, 0, 0, 0, 32'h00000011));
        tbl.push_back(v(0, 12'h010, 2'd0, 32'h0, 0, 3, 0, 0, 0, 0, 0, 0, 0, 32'h00000044));
        tbl.push_back(v(0, 12'h012, 2'd1, 32'h0, 0, 3, 0, 0, 0, 0, 0, 0, 0, 32'h00001122));
        tbl.push_back(v(1, 12'h011, 2'd0, 32'hFFFFFF5A, 0, 2, 1, 10'h004, 4'b0010, 32'h00005A00, 0, 0, 0, 0));
        tbl.push_back(v(0, 12'h010, 2'd2, 32'h0, 0, 3, 0, 0, 0, 0, 0, 0, 0, 32'h11225A44));
        tbl.push_back(v(1, 12'hFFF, 2'd0, 32'h00000077, 0, 2, 1, 10'h3FF, 4'b1000, 32'h77000000, 0, 0, 0, 0));
`ifdef DPRAM32_SPLIT_EN
        tbl.push_back(v(0, 12'hFFE, 2'd1, 32'h0, 0, 3, 0, 0, 0, 0, 0, 0, 0, 32'h000077EF));
`else
        tbl.push_back(v(0, 12'hFFE, 2'd1, 32'h0, 0, 3, 0, 0, 0, 0, 0, 0, 0, 32'h00007700));
`endif
        repeat (3) @(negedge clk);
        chk("rst_ack", {31'h0, ack}, 32'h0);
        chk("rst_err", {31'h0, err}, 32'h0);
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_ram_we", {31'h0, ram_we}, 32'h0);
        chk("rst_ram_be", {28'h0, ram_be}, 32'h0);
        chk("rst_ram_addr", {22'h0, ram_addr}, 32'h0);
        chk("rst_ram_din", ram_din, 32'h0);
        resetn = 1'b1;
        @(negedge clk);
        foreach (tbl[k]) run(tbl[k], k);
        // Reset during the first strobe cycle of a write.
        req = 1'b1; we = 1'b1; wdata = 32'h55AA55AA; size = 2'd2;
`ifdef DPRAM32_SPLIT_EN
        addr = 12'h01E;
`else
        addr = 12'h020;
`endif
        @(posedge clk);
        #1;
        req = 1'b0;
        #2;
        chk("mid_strobe_before_reset", {31'h0, ram_we}, 32'h1);
        resetn = 1'b0;
        #1;
        chk("mid_ram_we", {31'h0, ram_we}, 32'h0);
        chk("mid_ram_be", {28'h0, ram_be}, 32'h0);
        chk("mid_ack", {31'h0, ack}, 32'h0);
        chk("mid_ram_addr", {22'h0, ram_addr}, 32'h0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk($sformatf("mid_no_ack_%0d", c), {31'h0, ack}, 32'h0);
        end
        resetn = 1'b1;
        @(negedge clk);
        run(v(1, 12'h021, 2'd0, 32'h0000003C, 0, 2, 1, 10'h008, 4'b0010, 32'h00003C00, 0, 0, 0, 0), 100);
        run(v(0, 12'h020, 2'd2, 32'h0, 0, 3, 0, 0, 0, 0, 0, 0, 0, 32'h00003C00), 101);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
